// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- EX->MEM pipeline register of the 16-bit MIPS core.
//
// Holds up to two beats (main + skid) so the MEM stage can stall without a
// combinational ready path back into EX. in_ready is a flop: it drops only
// once both entries are occupied. beq/bne are resolved on accept; a taken
// branch produces a one-cycle branch_taken pulse carrying branch_pc. Branch
// beats still flow to MEM, but as bubbles (ctrl forced to 0).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   EX-side handshake
//   alu_res, zero         ALU result and zero flag
//   store_data            rt value for sw
//   br_target             precomputed PC+1+imm
//   rd_in, ctrl_in        destination reg, {mem_read,mem_write,reg_write,mem_to_reg}
//   br_eq, br_ne          beq / bne in this beat
//   flush                 synchronous kill of every held beat (highest priority)
//   out_valid / out_ready MEM-side handshake
//   out_addr, out_wdata, out_rd, out_ctrl   registered payload of the head beat
//   branch_taken, branch_pc                 taken-branch pulse and its target
//
// Optional: define EXMEM_FWD_EN to add fwd_valid / fwd_rd / fwd_data for the
// EX operand forwarding mux.

module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              zero,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] br_target,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [3:0]        ctrl_in,
  input  logic              br_eq,
  input  logic              br_ne,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,
  output logic [REG_W-1:0]  out_rd,
  output logic [3:0]        out_ctrl,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_pc
`ifdef EXMEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
    logic [3:0]        ctrl;
  } beat_t;

  beat_t             main_q, main_d, skid_q, skid_d, in_beat;
  logic              main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic              in_ready_q, in_ready_d;
  logic              branch_taken_q, branch_taken_d;
  logic [DATA_W-1:0] branch_pc_q, branch_pc_d;
  logic              accept, pop, is_br, taken;

  always_comb begin
    // flush masks both handshakes so it wins over accept and pop
    accept = in_valid && in_ready_q && !flush;
    pop    = main_vld_q && out_ready && !flush;
    is_br  = br_eq || br_ne;
    taken  = (br_eq && zero) || (br_ne && !zero);

    in_beat.addr  = alu_res;
    in_beat.wdata = store_data;
    in_beat.rd    = rd_in;
    in_beat.ctrl  = is_br ? 4'b0000 : ctrl_in;  // branches become MEM bubbles

    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q) begin
      // EMPTY
      if (accept) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end
    end else if (!skid_vld_q) begin
      // ONE
      if (accept && pop) begin
        main_d = in_beat;
      end else if (accept) begin
        skid_d     = in_beat;
        skid_vld_d = 1'b1;
      end else if (pop) begin
        main_vld_d = 1'b0;
      end
    end else begin
      // FULL: in_ready_q is low, so only a pop can happen
      if (pop) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end

    // ready for next cycle is known from next occupancy alone
    in_ready_d = !skid_vld_d;

    branch_taken_d = accept && taken;
    branch_pc_d    = (accept && taken) ? br_target : branch_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q         <= '0;
      skid_q         <= '0;
      main_vld_q     <= 1'b0;
      skid_vld_q     <= 1'b0;
      in_ready_q     <= 1'b1;
      branch_taken_q <= 1'b0;
      branch_pc_q    <= '0;
    end else begin
      main_q         <= main_d;
      skid_q         <= skid_d;
      main_vld_q     <= main_vld_d;
      skid_vld_q     <= skid_vld_d;
      in_ready_q     <= in_ready_d;
      branch_taken_q <= branch_taken_d;
      branch_pc_q    <= branch_pc_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_vld_q;
  assign out_addr     = main_q.addr;
  assign out_wdata    = main_q.wdata;
  assign out_rd       = main_q.rd;
  assign out_ctrl     = main_q.ctrl;
  assign branch_taken = branch_taken_q;
  assign branch_pc    = branch_pc_q;

`ifdef EXMEM_FWD_EN
  // ctrl[1] = reg_write, ctrl[0] = mem_to_reg; loads are not forwardable here
  assign fwd_valid = main_vld_q && main_q.ctrl[1] && !main_q.ctrl[0];
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.addr;
`endif

endmodule
